// File: rtl/mux2_arb_pkg.sv
// Shared types for the two-input packet-aware stream arbiter.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage

// File: rtl/mux2_out_reg.sv
// Purpose: valid/ready output register stage holding data, last and source select.
// Latency: one cycle from load to out_valid.
// Backpressure: contents held stable while out_valid && !out_ready; can_load gates upstream.
module mux2_out_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              load_sel,
    output logic              can_load,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_sel,
    input  logic              out_ready
);

    assign can_load = !out_valid || out_ready;

    // load is only asserted by the owner while can_load is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_last  <= load_last;
            out_sel   <= load_sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mux2_stream_arbiter.sv
// Purpose: round-robin 2:1 packet arbiter; grant locked to one input until its last beat (optional MUX2_ARB_STATS_EN grant counters).
// Latency: one cycle from input acceptance to out_valid; one beat per cycle sustained.
// Backpressure: both readys low while out_valid && !out_ready; non-granted input always stalled.
module mux2_stream_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int DATA_W = 8
`ifdef MUX2_ARB_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_last,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_last,
    output logic              in1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_sel,
    input  logic              out_ready
`ifdef MUX2_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  grant0_cnt,
    output logic [CNT_W-1:0]  grant1_cnt
`endif
);

    arb_state_e state, state_nxt;
    logic       last_sel, last_sel_nxt;
    logic       grant;
    logic       req_any;
    logic       can_load;
    logic       acc0, acc1;
    logic       load;

    // Idle-state pick: a lone requester wins, contention goes to the one not served last.
    always_comb begin
        req_any = in0_valid || in1_valid;
        grant   = CH0;
        if (in0_valid && in1_valid) begin
            grant = ~last_sel;
        end else if (in1_valid) begin
            grant = CH1;
        end
    end

    assign in0_ready = rst_n && can_load &&
                       ((state == LOCK0) || ((state == IDLE) && req_any && (grant == CH0)));
    assign in1_ready = rst_n && can_load &&
                       ((state == LOCK1) || ((state == IDLE) && req_any && (grant == CH1)));

    assign acc0 = in0_valid && in0_ready;
    assign acc1 = in1_valid && in1_ready;
    assign load = acc0 || acc1;

    always_comb begin
        state_nxt    = state;
        last_sel_nxt = last_sel;
        if (acc0) begin
            if (in0_last) begin
                state_nxt    = IDLE;
                last_sel_nxt = CH0;
            end else begin
                state_nxt    = LOCK0;
            end
        end else if (acc1) begin
            if (in1_last) begin
                state_nxt    = IDLE;
                last_sel_nxt = CH1;
            end else begin
                state_nxt    = LOCK1;
            end
        end
    end

    // last_sel resets to CH1 so in0 wins the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_sel <= CH1;
        end else begin
            state    <= state_nxt;
            last_sel <= last_sel_nxt;
        end
    end

    mux2_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (acc1 ? in1_data : in0_data),
        .load_last (acc1 ? in1_last : in0_last),
        .load_sel  (acc1 ? CH1 : CH0),
        .can_load  (can_load),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

`ifdef MUX2_ARB_STATS_EN
    // Counted on the last beat so each packet contributes exactly once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant0_cnt <= '0;
            grant1_cnt <= '0;
        end else begin
            if (acc0 && in0_last) grant0_cnt <= grant0_cnt + 1'b1;
            if (acc1 && in1_last) grant1_cnt <= grant1_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/mux2_stream_arbiter.md
# mux2_stream_arbiter

- Two-input, packet-aware, round-robin arbiter that merges two valid/ready data streams into one registered output stream.
- Sits directly upstream of the 2:1 selector datapath: it generates the select, drives the chosen data forward, and reports which input won.
- Whole packets are kept contiguous on the output by locking the grant until the packet's last beat.

## Interface
Parameters:
- DATA_W, 8, payload width of every data port.
- CNT_W, 16, width of the grant statistics counters (only used when `MUX2_ARB_STATS_EN` is defined).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; all state clears immediately on assertion.
- in0_valid  input  1  channel 0 beat available.
- in0_data  input  DATA_W  channel 0 payload.
- in0_last  input  1  channel 0 beat ends a packet.
- in0_ready  output  1  channel 0 beat accepted this cycle.
- in1_valid / in1_data / in1_last / in1_ready  same as channel 0, for channel 1.
- out_valid  output  1  registered output beat valid.
- out_data  output  DATA_W  registered payload.
- out_last  output  1  registered end-of-packet flag.
- out_sel  output  1  source of the current output beat: 0 = in0, 1 = in1.
- out_ready  input  1  downstream accepts the output beat.
- grant0_cnt / grant1_cnt  output  CNT_W  packets granted per channel (stats build only).

## Operation
- FSM states:
  - IDLE: no packet in progress.
  - LOCK0: packet from in0 in progress.
  - LOCK1: packet from in1 in progress.
- Round-robin pointer `last_sel` resets to 1, so in0 wins the first contention.
- Arbitration in IDLE:
  - Only in0_valid → grant 0. Only in1_valid → grant 1.
  - Both valid → grant !last_sel.
  - Neither valid → stay in IDLE.
- Grant takes effect in the same cycle: the winner's ready may be high in the cycle it is chosen.
- `can_load = !out_valid || out_ready`.
- in0_ready = can_load && (state==LOCK0 || (state==IDLE && grant==0)); in1_ready is symmetric. The non-granted channel's ready is always 0.
- On an accepted beat:
  - out_data, out_last and out_sel load from the granted channel; out_valid is set.
  - If the beat is not last, go to or stay in LOCKn.
  - If the beat is last, go to IDLE and set last_sel = n.
- Single-beat packet (last on the first beat): goes IDLE → IDLE, but last_sel still updates.
- In LOCKn the other channel is ignored regardless of its valid.
- out_valid clears when out_ready is high and no new beat loads in that cycle.
- Output-register contents are held stable while out_valid && !out_ready.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_last=0, out_sel=0
  - in0_ready=0 and in1_ready=0 while rst_n is low
  - state=IDLE, last_sel=1, counters=0
- Latency: one cycle from input acceptance to out_valid.
- Throughput: one beat per cycle with out_ready held high; no bubble between packets from alternating channels.
- Backpressure: no input is accepted while out_valid && !out_ready.
- Simultaneous out_ready and new accept: the output register reloads with no idle cycle.
- Reset mid-packet: the FSM returns to IDLE, the partial packet is dropped from the arbiter's view, and out_valid drops asynchronously.
- Counters wrap modulo 2^CNT_W.

## Configuration
- `MUX2_ARB_STATS_EN` defined: grant0_cnt and grant1_cnt exist. Each increments by 1 on acceptance of a packet's last beat from its channel.
- Macro undefined: the counter ports and logic are absent and the port list ends at out_ready. Arbitration behaviour is identical in both builds.

## Structure
- Shared package `mux2_arb_pkg`:
  - state enum `arb_state_e` {IDLE, LOCK0, LOCK1}
  - channel-index constants CH0=1'b0, CH1=1'b1
- Sub-module `mux2_out_reg`: the valid/ready output register stage holding data/last/sel, reusable by other stages.
- The arbiter FSM and pointer stay in the top module.

## Test plan
- Reset release; in0 sends a 3-beat packet (0x11, 0x22, 0x33, last on 0x33) with out_ready=1 → outputs appear at cycles +1..+3, out_sel=0, out_last on 0x33 only.
- Both channels valid from reset with single-beat packets (in0=0xA0, in1=0xB0) → order on the output is 0xA0, 0xB0, 0xA0, … with out_sel toggling every beat.
- in0 mid-packet (beat 2 of 4) while in1 asserts valid → in1_ready stays 0 until in0's last beat is accepted; in1 is granted the next cycle.
- out_ready held low for 5 cycles with out_valid=1 → out_data unchanged and both readys 0 throughout; on release, one beat per cycle resumes.
- rst_n asserted during a LOCK1 packet → out_valid=0 immediately; after release an in0 packet is granted first (last_sel=1).
- Stats build: 3 packets on in0 and 2 on in1 → grant0_cnt=3, grant1_cnt=2; non-stats build compiles and passes the first five tests.
